uart_rx_fifo: RTL
=================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, number of byte entries; power of two, 4..256.
REQ-002 Parameter AF_THRESH, default 12, occupancy at or above which almost_full asserts; 1..DEPTH.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset is asynchronous and active-high.
REQ-005 flush  input  1  synchronous clear of all stored entries.
REQ-006 in_valid  input  1  receiver has a byte on in_data; driven by the receiver's rx_data_valid.
REQ-007 in_data  input  8  received byte from the receiver.
REQ-008 in_ready  output  1  FIFO accepts in_data this cycle; drives the receiver's rx_data_ready.
REQ-009 out_valid  output  1  out_data holds the oldest stored byte.
REQ-010 out_data  output  8  oldest stored byte, first-word-fall-through.
REQ-011 out_ready  input  1  host consumes out_data this cycle.
REQ-012 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-013 almost_full  output  1  count >= AF_THRESH; host-side flow-control hint (RTS).

Function
REQ-014 Push = in_valid && in_ready; pop = out_valid && out_ready.
REQ-015 in_ready SHALL equal (count != DEPTH) && !flush, combinational from registered state only.
REQ-016 out_valid SHALL equal (count != 0); out_data SHALL be mem[rd_ptr], with no dependence on out_ready.
REQ-017 A pushed byte SHALL be visible on out_data with out_valid high on the cycle after the push edge (1-cycle latency); no same-cycle bypass.
REQ-018 Push writes mem[wr_ptr] and advances wr_ptr; pop advances rd_ptr. Both pointers are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0 naturally.
REQ-019 count: push only +1; pop only -1; push and pop together leaves count unchanged and both pointers advance.
REQ-020 Full (count == DEPTH): in_ready low, no write, no mem change. The receiver's overrun flag reports loss, and this block keeps no separate overflow state.
REQ-021 Empty (count == 0): out_valid low; out_ready ignored; pointers and count unchanged. out_data value is don't-care.
REQ-022 Full with out_ready high: pop occurs; in_ready rises the next cycle, not the same cycle.
REQ-023 flush high: next edge rd_ptr = wr_ptr = 0 and count = 0. Any push or pop that cycle is discarded, and flush overrides both.
REQ-024 almost_full SHALL be combinational from count.
REQ-025 No state machine beyond pointers/count; mem contents are not reset.

Reset
REQ-026 rst asserted: wr_ptr, rd_ptr and count SHALL clear immediately (asynchronous).
REQ-027 Outputs during and after reset: in_ready = 1, out_valid = 0, count = 0, almost_full = 0, out_data don't-care.
REQ-028 Reset mid-stream SHALL discard all entries. A byte offered on the same edge as reset release SHALL NOT be stored, and the first push is accepted on the following edge.

Structure
REQ-029 uart_pkg (shared) SHALL hold UART_DATA_W = 8 and typedef uart_byte_t, used by this block, the receiver and the transmitter.
REQ-030 No sub-module: storage array, pointers and count inline. A later TX-side FIFO instantiates its own copy; this block is not generalized.
REQ-031 The top-level buffered wrapper instantiates this block between the receiver and the host port, with in_ready wired to rx_data_ready.

Verification
REQ-032 Reset, then push 0xA5 -> next cycle out_valid = 1, out_data = 0xA5, count = 1. Pop -> count = 0, out_valid = 0.
REQ-033 Push 16 bytes 0x00..0x0F with no pops -> in_ready low after the 16th; almost_full high from count = 12. A 17th offer of 0xFF is not stored, and pops return 0x00..0x0F in order.
REQ-034 At count = 5, push and pop every cycle for 40 cycles -> count stays 5, pointers wrap at least twice, and output order matches input order.
REQ-035 Full, hold out_ready and in_valid high -> one pop on cycle N. in_ready high on N+1, count returns to 16 on N+2.
REQ-036 count = 9, assert flush with in_valid and out_ready both high -> count = 0, out_valid = 0 next cycle, and the offered byte is discarded.
REQ-037 Assert rst asynchronously mid-burst at count = 7 -> count = 0 and out_valid = 0 without waiting for a clock edge. A byte offered on the release edge is not stored.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver, transmitter and their FIFOs.
package uart_pkg;
  localparam int unsigned UART_DATA_W = 8;
  typedef logic [UART_DATA_W-1:0] uart_byte_t;
endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-side and host-side handshake bundle for the UART RX FIFO.
interface uart_rx_fifo_if #(parameter int unsigned DEPTH = 16);
  import uart_pkg::*;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             flush;
  logic             in_valid;
  uart_byte_t       in_data;
  logic             in_ready;
  logic             out_valid;
  uart_byte_t       out_data;
  logic             out_ready;
  logic [CNT_W-1:0] count;
  logic             almost_full;

  // Receiver + host side
  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count, almost_full
  );

  // FIFO side
  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count, almost_full
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO between the UART receiver and the host port.
// Storage, pointers and occupancy count are kept inline; mem contents are not reset.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_THRESH = 12
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_fifo_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  uart_byte_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // Flush blocks both sides so neither transfer is taken on a flush cycle
  assign w_push = bus.in_valid && !w_full && !bus.flush;
  assign w_pop  = !w_empty && bus.out_ready && !bus.flush;

  assign bus.in_ready    = !w_full && !bus.flush;
  assign bus.out_valid   = !w_empty;
  assign bus.out_data    = r_mem[r_rd_ptr];
  assign bus.count       = r_count;
  assign bus.almost_full = (r_count >= CNT_W'(AF_THRESH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.in_data;
  end
endmodule
